decryption_engine: RTL

DECRYPTION_ENGINE -- requirements
Module: decryption_engine

---
 rtl/decryption_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/decryption_engine.sv
// Block decryptor: loads a 4x4 byte matrix, undoes five keyed stages
// (rotate, row shift, column shift, bit rotate, invert), then streams it out.
module decryption_engine (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [2:0] {
        LOAD,
        D_ROT,
        D_ROW,
        D_COL,
        D_BAR,
        D_INV,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        key_q, key_d;
    logic [15:0][7:0]  m_q, m_d;
    logic              ov_q, ov_d;
    logic [7:0]        od_q, od_d;
    logic              ol_q, ol_d;
    logic              busy_q, busy_d;

    function automatic logic [7:0] ror8(input logic [7:0] b,
                                        input logic [1:0] n);
        logic [15:0] t;
        t = {b, b} >> n;
        return t[7:0];
    endfunction

    assign in_ready  = (state_q == LOAD) && !rst;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            key_q   <= '0;
            m_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            m_q     <= m_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            busy_q  <= busy_d;
        end
    end

    // Matrix index is {row, col}; each processing state rewrites all 16 bytes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        m_d     = m_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        busy_d  = busy_q;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    m_d[cnt_q] = in_data;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd0) begin
                        key_d  = key;
                        busy_d = 1'b1;
                    end
                    if (cnt_q == 4'd15) begin
                        state_d = D_ROT;
                    end
                end
            end
            D_ROT: begin
                if (key_q[7]) begin
                    for (int r = 0; r < 4; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            m_d[{2'(r), 2'(c)}] = m_q[{2'(c), 2'(3 - r)}];
                        end
                    end
                end
                state_d = D_ROW;
            end
            D_ROW: begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        m_d[{2'(r), 2'(c)}] =
                            m_q[{2'(r), 2'(c) - key_q[6:5]}];
                    end
                end
                state_d = D_COL;
            end
            D_COL: begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        m_d[{2'(r), 2'(c)}] =
                            m_q[{2'(r) + key_q[4:3], 2'(c)}];
                    end
                end
                state_d = D_BAR;
            end
            D_BAR: begin
                for (int i = 0; i < 16; i++) begin
                    m_d[i] = ror8(m_q[i], key_q[2:1]);
                end
                state_d = D_INV;
            end
            D_INV: begin
                if (key_q[0]) begin
                    m_d = ~m_q;
                end
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                // First SEND cycle primes the output register.
                if (!ov_q) begin
                    ov_d = 1'b1;
                    od_d = m_q[cnt_q];
                    ol_d = (cnt_q == 4'd15);
                end else if (out_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        ov_d    = 1'b0;
                        od_d    = '0;
                        ol_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        od_d  = m_q[cnt_q + 4'd1];
                        ol_d  = (cnt_q == 4'd14);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
